// File: rtl/inst_enc_sbm.sv
`default_nettype none
// ============================================================================
// Module   : inst_enc_sbm (with package inst_enc_sbm_pkg)
// Brief    : RV32I instruction encoder. Packs decoded fields and a full
//            32-bit immediate into an instruction word, flags immediates that
//            the selected format cannot represent, and queues results in a
//            2-entry valid/ready output FIFO.
// Revision : 1.0 - initial release
// ============================================================================

package inst_enc_sbm_pkg;
  typedef enum logic [2:0] {
    INST_TYPE_R = 3'd0,
    INST_TYPE_I = 3'd1,
    INST_TYPE_S = 3'd2,
    INST_TYPE_B = 3'd3,
    INST_TYPE_U = 3'd4,
    INST_TYPE_J = 3'd5
  } cs_inst_type;
endpackage

module inst_enc_sbm
  import inst_enc_sbm_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  cs_inst_type      inst_type_i,
  input  logic [6:0]       opcode_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [31:0]      imm_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      inst_o,
  output logic             err_o,
  output logic [CNT_W-1:0] enc_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [1:0]       c_depth   = FIFO_DEPTH[1:0];
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  // Head entry drives the outputs directly; tail only holds the second entry.
  logic [1:0]       r_count;
  logic [31:0]      r_head_inst;
  logic             r_head_err;
  logic [31:0]      r_tail_inst;
  logic             r_tail_err;
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [31:0] w_raw;
  logic        w_err;
  logic [31:0] w_enc;
  logic        w_ready;
  logic        w_push;
  logic        w_pop;

  // Representability: the immediate must be a sign extension of its top
  // encodable bit; branch/jump targets must also be halfword aligned.
  logic w_fit12;
  logic w_fit13;
  logic w_fit21;
  assign w_fit12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign w_fit13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign w_fit21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  // Field packing and range check for the selected instruction format.
  always_comb begin
    w_raw = 32'h0000_0000;
    w_err = 1'b0;
    case (inst_type_i)
      INST_TYPE_R: begin
        w_raw = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      INST_TYPE_I: begin
        w_raw = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        w_err = ~w_fit12;
      end
      INST_TYPE_S: begin
        w_raw = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        w_err = ~w_fit12;
      end
      INST_TYPE_B: begin
        w_raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                 imm_i[4:1], imm_i[11], opcode_i};
        w_err = ~w_fit13 | imm_i[0];
      end
      INST_TYPE_U: begin
        w_raw = {imm_i[31:12], rd_i, opcode_i};
        w_err = |imm_i[11:0];
      end
      INST_TYPE_J: begin
        w_raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        w_err = ~w_fit21 | imm_i[0];
      end
      default: begin
        w_err = 1'b1;
      end
    endcase
  end

  // A rejected request is stored as the all-zero illegal instruction.
  assign w_enc   = w_err ? 32'h0000_0000 : w_raw;
  assign w_ready = (r_count < c_depth) && !flush_i;
  assign w_push  = valid_i && w_ready;
  assign w_pop   = (r_count != 2'd0) && ready_i;

  // Two-entry FIFO: head/tail shuffle; head data is left untouched on empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count     <= 2'd0;
      r_head_inst <= 32'h0000_0000;
      r_head_err  <= 1'b0;
      r_tail_inst <= 32'h0000_0000;
      r_tail_err  <= 1'b0;
    end else if (flush_i) begin
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head_inst <= w_enc;
            r_head_err  <= w_err;
            r_count     <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head_inst <= w_enc;
            r_head_err  <= w_err;
          end else if (w_push) begin
            r_tail_inst <= w_enc;
            r_tail_err  <= w_err;
            r_count     <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_head_inst <= r_tail_inst;
            r_head_err  <= r_tail_err;
            r_count     <= 2'd1;
          end
        end
      endcase
    end
  end

  // Saturating statistics; flush does not touch them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_push) begin
      if (r_enc_cnt != c_cnt_max) begin
        r_enc_cnt <= r_enc_cnt + c_cnt_one;
      end
      if (w_err && (r_err_cnt != c_cnt_max)) begin
        r_err_cnt <= r_err_cnt + c_cnt_one;
      end
    end
  end

  assign ready_o   = w_ready;
  assign valid_o   = (r_count != 2'd0);
  assign inst_o    = r_head_inst;
  assign err_o     = r_head_err;
  assign enc_cnt_o = r_enc_cnt;
  assign err_cnt_o = r_err_cnt;

endmodule
`default_nettype wire
